// File: rtl/ilowx_mem_responder.sv
// Far end of the ilowX instruction-fetch interface: serves one cached line fill or one
// uncached word at a time from a word-addressed synchronous RAM after a fixed wait.
module ilowx_mem_responder #(
  parameter int               XLEN      = 32,
  parameter int               BLK_SIZE  = 128,
  parameter int               MEM_WORDS = 16384,
  parameter logic [XLEN-1:0]  BASE_ADDR = 'h4000_0000,
  parameter int               LATENCY   = 4,
  parameter string            INIT_FILE = ""
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                lx_ireq_valid_i,
  input  logic                lx_ireq_ready_i,
  input  logic [XLEN-1:0]     lx_ireq_addr_i,
  input  logic                lx_ireq_uncached_i,
  output logic                lx_ires_valid_o,
  output logic                lx_ires_ready_o,
  output logic [BLK_SIZE-1:0] lx_ires_blk_o
);

  localparam int BEATS     = BLK_SIZE / XLEN;
  localparam int LW        = $clog2(BEATS);
  localparam int BW        = LW + 1;
  localparam int AW        = $clog2(MEM_WORDS);
  localparam int BLK_BYTES = BLK_SIZE / 8;
  localparam int CW        = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
  localparam logic [XLEN-1:0] LINE_MASK = ~(XLEN'(BLK_BYTES) - XLEN'(1));

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST, S_RESP} state_e;

  logic [XLEN-1:0] mem [MEM_WORDS];

  state_e            state_q, state_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [LW-1:0]     lane_q, lane_d;
  logic              unc_q, unc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic [BLK_SIZE-1:0] blk_q, blk_d;
  logic              valid_q, valid_d;
  logic [XLEN-1:0]   rdata_q;
  logic [AW-1:0]     rd_idx;
  logic [BW-1:0]     nreads;
  logic [LW-1:0]     cap_lane;
  logic [XLEN-1:0]   off;

  always_comb begin
    off      = (lx_ireq_uncached_i ? lx_ireq_addr_i : (lx_ireq_addr_i & LINE_MASK)) - BASE_ADDR;
    nreads   = unc_q ? BW'(1) : BW'(BEATS);
    rd_idx   = unc_q ? idx_q : idx_q + AW'(beat_q);
    // The word read on beat k lands in the block one cycle later, on beat k+1.
    cap_lane = unc_q ? lane_q : LW'(beat_q - BW'(1));

    state_d = state_q;
    idx_d   = idx_q;
    lane_d  = lane_q;
    unc_d   = unc_q;
    cnt_d   = cnt_q;
    beat_d  = beat_q;
    blk_d   = blk_q;
    valid_d = valid_q;

    case (state_q)
      S_IDLE: begin
        valid_d = 1'b0;
        if (lx_ireq_valid_i) begin
          idx_d  = AW'(off >> 2);
          lane_d = LW'(lx_ireq_addr_i >> 2);
          unc_d  = lx_ireq_uncached_i;
          blk_d  = '0;
          beat_d = '0;
          if (LATENCY == 0) begin
            state_d = S_BURST;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CW'(LATENCY);
          end
        end
      end
      S_WAIT: begin
        if (cnt_q <= CW'(1)) begin
          state_d = S_BURST;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_BURST: begin
        beat_d = beat_q + BW'(1);
        if (beat_q != '0) begin
          blk_d[cap_lane*XLEN +: XLEN] = rdata_q;
        end
        if (beat_q == nreads) begin
          state_d = S_RESP;
          valid_d = 1'b1;
          beat_d  = '0;
        end
      end
      S_RESP: begin
        if (lx_ireq_ready_i) begin
          state_d = S_IDLE;
          valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      lane_q  <= '0;
      unc_q   <= 1'b0;
      cnt_q   <= '0;
      beat_q  <= '0;
      blk_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      lane_q  <= lane_d;
      unc_q   <= unc_d;
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
      blk_q   <= blk_d;
      valid_q <= valid_d;
    end
  end

  // Synchronous RAM read port; the address is free-running and only consumed in BURST.
  always_ff @(posedge clk_i) begin
    rdata_q <= mem[rd_idx];
  end

  assign lx_ires_valid_o = valid_q;
  assign lx_ires_blk_o   = blk_q;
  assign lx_ires_ready_o = rst_ni && (state_q == S_IDLE);

endmodule

// File: tb/tb_ilowx_mem_responder.sv
// Directed bench for ilowx_mem_responder: a LATENCY=4 instance driven from a vector
// table plus hand-written backpressure/abort sequences, and a LATENCY=0 instance.
module tb_ilowx_mem_responder;

  localparam int MW = 16384;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         req_valid, req_ready, req_unc;
  logic [31:0]  req_addr;
  logic         res_valid, res_ready;
  logic [127:0] res_blk;

  logic         r0_valid, r0_ready, r0_unc;
  logic [31:0]  r0_addr;
  logic         o0_valid, o0_ready;
  logic [127:0] o0_blk;

  ilowx_mem_responder dut (
    .clk_i(clk), .rst_ni(rst_n),
    .lx_ireq_valid_i(req_valid), .lx_ireq_ready_i(req_ready),
    .lx_ireq_addr_i(req_addr), .lx_ireq_uncached_i(req_unc),
    .lx_ires_valid_o(res_valid), .lx_ires_ready_o(res_ready), .lx_ires_blk_o(res_blk)
  );

  ilowx_mem_responder #(.LATENCY(0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n),
    .lx_ireq_valid_i(r0_valid), .lx_ireq_ready_i(r0_ready),
    .lx_ireq_addr_i(r0_addr), .lx_ireq_uncached_i(r0_unc),
    .lx_ires_valid_o(o0_valid), .lx_ires_ready_o(o0_ready), .lx_ires_blk_o(o0_blk)
  );

  // scoreboard
  logic [127:0] exp_q[$];
  int n_cmp = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0]  addr;
    logic         unc;
    logic [127:0] blk;
    int           lat;
  } vec_t;

  vec_t tbl[8];
  vec_t tbl0[2];

  function automatic logic [31:0] word_of(int i);
    if (i == 2) return 32'hDEAD_BEEF;
    if (i >= 4 && i <= 7) return 32'hA0A0_0000 + 32'(i - 4);
    return 32'h5A00_0000 | 32'(i);
  endfunction

  task automatic check_blk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // driver tasks
  task automatic do_req(input logic [31:0] a, input logic u);
    int n;
    n = 0;
    while (!res_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    req_valid = 1'b1; req_addr = a; req_unc = u;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_unc   = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_resp(output int lat);
    lat = 0;
    while (!res_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  // watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [127:0] e;
    logic seen;

    for (int i = 0; i < MW; i++) begin
      dut.mem[i]  = word_of(i);
      dut0.mem[i] = word_of(i);
    end

    tbl[0] = '{32'h4000_0014, 1'b0, {32'hA0A0_0003, 32'hA0A0_0002, 32'hA0A0_0001, 32'hA0A0_0000}, 9};
    tbl[1] = '{32'h4000_0008, 1'b1, 128'h0000_0000_DEAD_BEEF_0000_0000_0000_0000, 6};
    tbl[2] = '{32'h4000_001F, 1'b1, {32'hA0A0_0003, 96'h0}, 6};
    tbl[3] = '{32'h4000_FFF4, 1'b0, {32'h5A00_3FFF, 32'h5A00_3FFE, 32'h5A00_3FFD, 32'h5A00_3FFC}, 9};
    tbl[4] = '{32'h4001_0000, 1'b0, {32'h5A00_0003, 32'hDEAD_BEEF, 32'h5A00_0001, 32'h5A00_0000}, 9};
    tbl[5] = '{32'h3FFF_FFF0, 1'b0, {32'h5A00_3FFF, 32'h5A00_3FFE, 32'h5A00_3FFD, 32'h5A00_3FFC}, 9};
    tbl[6] = '{32'h4000_0010, 1'b1, {96'h0, 32'hA0A0_0000}, 6};
    tbl[7] = '{32'h4001_0004, 1'b1, {64'h0, 32'h5A00_0001, 32'h0}, 6};

    tbl0[0] = '{32'h4000_0014, 1'b0, {32'hA0A0_0003, 32'hA0A0_0002, 32'hA0A0_0001, 32'hA0A0_0000}, 5};
    tbl0[1] = '{32'h4000_0008, 1'b1, 128'h0000_0000_DEAD_BEEF_0000_0000_0000_0000, 2};

    req_valid = 1'b0; req_ready = 1'b0; req_unc = 1'b0; req_addr = '0;
    r0_valid = 1'b0; r0_ready = 1'b1; r0_unc = 1'b0; r0_addr = '0;

    // reset
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_int("reset_valid", int'(res_valid), 0);
    check_int("reset_ready", int'(res_ready), 0);
    check_blk("reset_blk", res_blk, '0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_int("release_ready", int'(res_ready), 1);

    // table-driven transactions with ready_i held high
    req_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(tbl[i].blk);
      do_req(tbl[i].addr, tbl[i].unc);
      check_int($sformatf("v%0d_busy_ready", i), int'(res_ready), 0);
      wait_resp(lat);
      check_int($sformatf("v%0d_latency", i), lat, tbl[i].lat);
      e = exp_q.pop_front();
      check_blk($sformatf("v%0d_blk", i), res_blk, e);
      @(posedge clk); #1;
      check_int($sformatf("v%0d_valid_drop", i), int'(res_valid), 0);
      check_int($sformatf("v%0d_ready_rise", i), int'(res_ready), 1);
    end

    // backpressure in RESP
    req_ready = 1'b0;
    exp_q.push_back({32'h5A00_000B, 32'h5A00_000A, 32'h5A00_0009, 32'h5A00_0008});
    do_req(32'h4000_0020, 1'b0);
    wait_resp(lat);
    check_int("bp_latency", lat, 9);
    e = exp_q.pop_front();
    check_blk("bp_blk", res_blk, e);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check_int($sformatf("bp%0d_valid", k), int'(res_valid), 1);
      check_blk($sformatf("bp%0d_blk", k), res_blk, e);
      check_int($sformatf("bp%0d_ready", k), int'(res_ready), 0);
    end
    req_ready = 1'b1;
    @(posedge clk); #1;
    check_int("bp_valid_drop", int'(res_valid), 0);
    check_int("bp_ready_rise", int'(res_ready), 1);

    // reset during BURST aborts the transaction
    do_req(32'h4000_0030, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_int("abort_valid", int'(res_valid), 0);
    check_int("abort_ready", int'(res_ready), 0);
    check_blk("abort_blk", res_blk, '0);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      if (res_valid) seen = 1'b1;
    end
    check_int("abort_no_resp", int'(seen), 0);
    check_int("abort_ready_back", int'(res_ready), 1);
    exp_q.push_back({32'h5A00_0013, 32'h5A00_0012, 32'h5A00_0011, 32'h5A00_0010});
    do_req(32'h4000_0040, 1'b0);
    wait_resp(lat);
    check_int("post_abort_latency", lat, 9);
    e = exp_q.pop_front();
    check_blk("post_abort_blk", res_blk, e);
    @(posedge clk); #1;
    check_int("post_abort_valid_drop", int'(res_valid), 0);

    // zero-latency instance
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(tbl0[i].blk);
      r0_valid = 1'b1; r0_addr = tbl0[i].addr; r0_unc = tbl0[i].unc;
      @(posedge clk); #1;
      r0_valid = 1'b0;
      lat = 0;
      while (!o0_valid && lat < 100) begin
        @(posedge clk); #1; lat++;
      end
      check_int($sformatf("l0_%0d_latency", i), lat, tbl0[i].lat);
      e = exp_q.pop_front();
      check_blk($sformatf("l0_%0d_blk", i), o0_blk, e);
      @(posedge clk); #1;
      check_int($sformatf("l0_%0d_valid_drop", i), int'(o0_valid), 0);
      check_int($sformatf("l0_%0d_ready_rise", i), int'(o0_ready), 1);
    end

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
